// File: rtl/alu_mon_pkg.sv
// Shared definitions for the ALU trojan monitor.
//   OPND_W      : operand / result width of the monitored ALU
//   alu_op_e    : op encodings (ADD, SUB, AND, OR)
//   mon_state_e : monitor FSM states (IDLE, ARMED, ALARM)
//   alu_flags_t : result plus carry/zero/overflow flags
package alu_mon_pkg;

  localparam int unsigned OPND_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ALARM
  } mon_state_e;

  typedef struct packed {
    logic [OPND_W-1:0] result;
    logic              carry;
    logic              zero;
    logic              overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit ALU under observation.
// Ports:
//   A, B      in  operands
//   op        in  00 ADD, 01 SUB, 10 AND, 11 OR
//   result    out 4-bit result
//   carry     out ADD carry-out / SUB unsigned borrow (A<B); 0 for logic ops
//   zero      out result == 0
//   overflow  out two's-complement overflow for ADD/SUB; 0 for logic ops
module alu_ref_model
  import alu_mon_pkg::*;
(
  input  logic [OPND_W-1:0] A,
  input  logic [OPND_W-1:0] B,
  input  logic [1:0]        op,
  output logic [OPND_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              overflow
);

  localparam int unsigned MSB = OPND_W - 1;

  logic [OPND_W:0] sum_w;
  logic [OPND_W:0] diff_w;

  always_comb begin
    sum_w    = {1'b0, A} + {1'b0, B};
    // Extra bit of the difference is the unsigned borrow.
    diff_w   = {1'b0, A} - {1'b0, B};
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (alu_op_e'(op))
      OP_ADD: begin
        result   = sum_w[OPND_W-1:0];
        carry    = sum_w[OPND_W];
        overflow = (A[MSB] == B[MSB]) && (sum_w[MSB] != A[MSB]);
      end
      OP_SUB: begin
        result   = diff_w[OPND_W-1:0];
        carry    = diff_w[OPND_W];
        overflow = (A[MSB] != B[MSB]) && (diff_w[MSB] != A[MSB]);
      end
      OP_AND: result = A & B;
      OP_OR:  result = A | B;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_trojan_monitor.sv
// Runtime monitor that checks a 4-bit ALU against a golden model and raises a
// sticky alarm once the number of mismatches reaches MISMATCH_THRESH.
// Parameters:
//   CNT_W           width of check/mismatch counters (saturating)
//   MISMATCH_THRESH mismatch count that triggers the alarm (1..2^CNT_W-1)
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid, A, B, op               operands sampled by the monitored ALU
//   dut_result, dut_carry,
//   dut_zero, dut_overflow           ALU outputs, one cycle after in_valid
//   alarm_clr                        sync clear of alarm, counters, capture
//   alarm                            sticky trojan-detected flag
//   mismatch                         pulse in the cycle a check fails
//   check_cnt, mismatch_cnt          saturating counters
//   fail_A, fail_B, fail_op          operands of first mismatch since clear
// Optional build macro ALU_MON_PEROP_STATS_EN adds per_op_mismatch, four
// 8-bit saturating mismatch counters indexed by op.
module alu_trojan_monitor
  import alu_mon_pkg::*;
#(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned MISMATCH_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [OPND_W-1:0] A,
  input  logic [OPND_W-1:0] B,
  input  logic [1:0]        op,
  input  logic [OPND_W-1:0] dut_result,
  input  logic              dut_carry,
  input  logic              dut_zero,
  input  logic              dut_overflow,
  input  logic              alarm_clr,
  output logic              alarm,
  output logic              mismatch,
  output logic [CNT_W-1:0]  check_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [OPND_W-1:0] fail_A,
  output logic [OPND_W-1:0] fail_B,
  output logic [1:0]        fail_op
`ifdef ALU_MON_PEROP_STATS_EN
  ,
  output logic [3:0][7:0]   per_op_mismatch
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(MISMATCH_THRESH);

  mon_state_e        state_q, state_d;
  logic              pend_q, pend_d;
  logic [OPND_W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [CNT_W-1:0]  chk_q, chk_d, mis_q, mis_d;
  logic [OPND_W-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic [1:0]        fail_op_q, fail_op_d;
  logic              thresh_hit;
  alu_flags_t        gold_w, obs_w;

  alu_ref_model u_ref (
    .A        (a_q),
    .B        (b_q),
    .op       (op_q),
    .result   (gold_w.result),
    .carry    (gold_w.carry),
    .zero     (gold_w.zero),
    .overflow (gold_w.overflow)
  );

  assign obs_w    = '{result: dut_result, carry: dut_carry,
                      zero: dut_zero, overflow: dut_overflow};
  assign mismatch = pend_q && (obs_w != gold_w);

  // Clear is applied before the current check is accounted, so a check
  // coinciding with alarm_clr lands in freshly zeroed counters.
  always_comb begin
    pend_d    = in_valid;
    a_d       = in_valid ? A  : a_q;
    b_d       = in_valid ? B  : b_q;
    op_d      = in_valid ? op : op_q;
    chk_d     = alarm_clr ? '0 : chk_q;
    mis_d     = alarm_clr ? '0 : mis_q;
    fail_a_d  = alarm_clr ? '0 : fail_a_q;
    fail_b_d  = alarm_clr ? '0 : fail_b_q;
    fail_op_d = alarm_clr ? '0 : fail_op_q;
    if (pend_q && (chk_d != '1)) chk_d = chk_d + CNT_ONE;
    if (mismatch) begin
      // The count saturates and never wraps, so zero means "nothing
      // captured since reset/clear".
      if (mis_d == '0) begin
        fail_a_d  = a_q;
        fail_b_d  = b_q;
        fail_op_d = op_q;
      end
      if (mis_d != '1) mis_d = mis_d + CNT_ONE;
    end
  end

  assign thresh_hit = (mis_d >= THRESH_C);

  always_comb begin
    state_d = state_q;
    if (alarm_clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (thresh_hit) state_d = ALARM;
                 else if (in_valid) state_d = ARMED;
        ARMED:   if (thresh_hit) state_d = ALARM;
        ALARM:   state_d = ALARM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      chk_q     <= '0;
      mis_q     <= '0;
      fail_a_q  <= '0;
      fail_b_q  <= '0;
      fail_op_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      chk_q     <= chk_d;
      mis_q     <= mis_d;
      fail_a_q  <= fail_a_d;
      fail_b_q  <= fail_b_d;
      fail_op_q <= fail_op_d;
    end
  end

  assign alarm        = (state_q == ALARM);
  assign check_cnt    = chk_q;
  assign mismatch_cnt = mis_q;
  assign fail_A       = fail_a_q;
  assign fail_B       = fail_b_q;
  assign fail_op      = fail_op_q;

`ifdef ALU_MON_PEROP_STATS_EN
  logic [3:0][7:0] perop_q, perop_d;

  always_comb begin
    perop_d = alarm_clr ? '0 : perop_q;
    if (mismatch && (perop_d[op_q] != '1)) perop_d[op_q] = perop_d[op_q] + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perop_q <= '0;
    else        perop_q <= perop_d;
  end

  assign per_op_mismatch = perop_q;
`endif

endmodule

// File: tb/tb_alu_trojan_monitor.sv
module tb_alu_trojan_monitor;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, alarm_clr;
  logic [3:0] A, B, dut_result;
  logic [1:0] op;
  logic       dut_carry, dut_zero, dut_overflow;

  logic       mm_w [3];
  logic       al_w [3];
  logic [3:0] fa_w [3];
  logic [3:0] fb_w [3];
  logic [1:0] fo_w [3];
  logic [15:0] chk0, chk1, mis0, mis1;
  logic [1:0]  chk2, mis2;
`ifdef ALU_MON_PEROP_STATS_EN
  logic [3:0][7:0] pom0, pom1, pom2;
`endif

  always #5 clk = ~clk;

  // Instance 0: defaults; instance 1: threshold 3; instance 2: 2-bit counters.
  alu_trojan_monitor #(.CNT_W(16), .MISMATCH_THRESH(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .op(op),
    .dut_result(dut_result), .dut_carry(dut_carry), .dut_zero(dut_zero),
    .dut_overflow(dut_overflow), .alarm_clr(alarm_clr), .alarm(al_w[0]),
    .mismatch(mm_w[0]), .check_cnt(chk0), .mismatch_cnt(mis0),
    .fail_A(fa_w[0]), .fail_B(fb_w[0]), .fail_op(fo_w[0])
`ifdef ALU_MON_PEROP_STATS_EN
    , .per_op_mismatch(pom0)
`endif
  );

  alu_trojan_monitor #(.CNT_W(16), .MISMATCH_THRESH(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .op(op),
    .dut_result(dut_result), .dut_carry(dut_carry), .dut_zero(dut_zero),
    .dut_overflow(dut_overflow), .alarm_clr(alarm_clr), .alarm(al_w[1]),
    .mismatch(mm_w[1]), .check_cnt(chk1), .mismatch_cnt(mis1),
    .fail_A(fa_w[1]), .fail_B(fb_w[1]), .fail_op(fo_w[1])
`ifdef ALU_MON_PEROP_STATS_EN
    , .per_op_mismatch(pom1)
`endif
  );

  alu_trojan_monitor #(.CNT_W(2), .MISMATCH_THRESH(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .op(op),
    .dut_result(dut_result), .dut_carry(dut_carry), .dut_zero(dut_zero),
    .dut_overflow(dut_overflow), .alarm_clr(alarm_clr), .alarm(al_w[2]),
    .mismatch(mm_w[2]), .check_cnt(chk2), .mismatch_cnt(mis2),
    .fail_A(fa_w[2]), .fail_B(fb_w[2]), .fail_op(fo_w[2])
`ifdef ALU_MON_PEROP_STATS_EN
    , .per_op_mismatch(pom2)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model state (per instance where parameters differ).
  int cmax [3] = '{65535, 65535, 3};
  int thr  [3] = '{1, 3, 1};
  int m_chk [3];
  int m_mis [3];
  int m_st  [3];   // 0 idle, 1 armed, 2 alarm
  int m_fa [3];
  int m_fb [3];
  int m_fo [3];
  bit m_pend;
  int m_ra, m_rb, m_rop;
  bit exp_mm;
  bit obs_mm [3];

  function automatic int dchk(int i);
    case (i)
      0: return int'(chk0);
      1: return int'(chk1);
      default: return int'(chk2);
    endcase
  endfunction

  function automatic int dmis(int i);
    case (i)
      0: return int'(mis0);
      1: return int'(mis1);
      default: return int'(mis2);
    endcase
  endfunction

  // Golden ALU computed with plain integer arithmetic.
  function automatic void golden(input int a, input int b, input int o,
                                 output int r, output bit c, output bit z,
                                 output bit v);
    int sa, sb, s;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    c = 1'b0;
    v = 1'b0;
    case (o)
      0: begin
        s = a + b; r = s % 16; c = (s > 15);
        v = ((sa + sb) > 7) || ((sa + sb) < -8);
      end
      1: begin
        s = a - b; r = (s + 16) % 16; c = (a < b);
        v = ((sa - sb) > 7) || ((sa - sb) < -8);
      end
      2: r = a & b;
      default: r = a | b;
    endcase
    z = (r == 0);
  endfunction

  function automatic void model_clear_all();
    for (int i = 0; i < 3; i++) begin
      m_chk[i] = 0; m_mis[i] = 0; m_st[i] = 0;
      m_fa[i] = 0; m_fb[i] = 0; m_fo[i] = 0;
    end
    m_pend = 1'b0;
    m_ra = 0; m_rb = 0; m_rop = 0;
  endfunction

  // One clock cycle: called just after a falling edge, returns at the next one.
  task automatic tick(input bit v, input int a, input int b, input int o,
                      input int r, input bit c, input bit z, input bit ov,
                      input bit clr);
    int gr;
    bit gc, gz, gv;
    in_valid = v; A = a[3:0]; B = b[3:0]; op = o[1:0];
    dut_result = r[3:0]; dut_carry = c; dut_zero = z; dut_overflow = ov;
    alarm_clr = clr;
    #1;
    golden(m_ra, m_rb, m_rop, gr, gc, gz, gv);
    exp_mm = m_pend && ((r != gr) || (c != gc) || (z != gz) || (ov != gv));
    for (int i = 0; i < 3; i++) obs_mm[i] = mm_w[i];
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        m_chk[i] = 0; m_mis[i] = 0; m_fa[i] = 0; m_fb[i] = 0; m_fo[i] = 0;
      end
      if (m_pend && m_chk[i] < cmax[i]) m_chk[i]++;
      if (exp_mm) begin
        if (m_mis[i] == 0) begin
          m_fa[i] = m_ra; m_fb[i] = m_rb; m_fo[i] = m_rop;
        end
        if (m_mis[i] < cmax[i]) m_mis[i]++;
      end
      if (clr) m_st[i] = 0;
      else if (m_st[i] != 2) begin
        if (m_mis[i] >= thr[i]) m_st[i] = 2;
        else if (m_st[i] == 0 && v) m_st[i] = 1;
      end
    end
    m_pend = v;
    if (v) begin m_ra = a; m_rb = b; m_rop = o; end
    @(negedge clk);
  endtask

  // Response that is the golden value for the pending op, optionally corrupted.
  task automatic respond(input bit v, input int a, input int b, input int o,
                         input bit corrupt, input bit clr);
    int gr;
    bit gc, gz, gv;
    golden(m_ra, m_rb, m_rop, gr, gc, gz, gv);
    if (corrupt) gr = gr ^ 1;
    tick(v, a, b, o, gr, gc, gz, gv, clr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_clear_all();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 0; alarm_clr = 0; A = 0; B = 0; op = 0;
    dut_result = 4'hF; dut_carry = 1; dut_zero = 1; dut_overflow = 1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (al_w[i] !== 1'b0 || mm_w[i] !== 1'b0 || dchk(i) != 0 || dmis(i) != 0
          || fa_w[i] !== 4'd0 || fb_w[i] !== 4'd0 || fo_w[i] !== 2'd0) begin
        failures++;
        $display("FAIL reset_outputs inst%0d alarm=%0b mm=%0b chk=%0d mis=%0d fa=%0d fb=%0d fo=%0d required all 0",
                 i, al_w[i], mm_w[i], dchk(i), dmis(i), fa_w[i], fb_w[i], fo_w[i]);
      end
    end
    model_clear_all();
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic();
    tick(1, 7, 9, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1, 1, 0, 0);
    checks++;
    if (obs_mm[0] !== 1'b0) begin
      failures++; $display("FAIL add_7_9_mismatch got=%0b exp=0", obs_mm[0]);
    end
    checks++;
    if (dchk(0) != 1) begin
      failures++; $display("FAIL add_7_9_check_cnt got=%0d exp=1", dchk(0));
    end
  endtask

  task automatic test_sub_capture();
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(1, 3, 5, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 'hE, 1, 0, 0, 0);
    checks++;
    if (obs_mm[0] !== 1'b0 || al_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL sub_3_5_ok mm=%0b alarm=%0b exp mm=0 alarm=0", obs_mm[0], al_w[0]);
    end
    tick(1, 3, 5, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 'hF, 1, 0, 0, 0);
    checks++;
    if (obs_mm[0] !== 1'b1) begin
      failures++; $display("FAIL sub_3_5_bad_mismatch got=%0b exp=1", obs_mm[0]);
    end
    checks++;
    if (fa_w[0] !== 4'd3 || fb_w[0] !== 4'd5 || fo_w[0] !== 2'b01) begin
      failures++;
      $display("FAIL sub_capture got A=%0d B=%0d op=%0d exp A=3 B=5 op=1", fa_w[0], fb_w[0], fo_w[0]);
    end
    checks++;
    if (al_w[0] !== 1'b1 || al_w[1] !== 1'b0) begin
      failures++;
      $display("FAIL sub_alarm got t1=%0b t3=%0b exp t1=1 t3=0", al_w[0], al_w[1]);
    end
  endtask

  task automatic test_overflow();
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(1, 7, 1, 0, 0, 0, 0, 0, 0);
    tick(1, 7, 1, 0, 8, 0, 0, 1, 0);
    checks++;
    if (obs_mm[0] !== 1'b0) begin
      failures++; $display("FAIL add_ovf_set got=%0b exp=0", obs_mm[0]);
    end
    tick(0, 0, 0, 0, 8, 0, 0, 0, 0);
    checks++;
    if (obs_mm[0] !== 1'b1) begin
      failures++; $display("FAIL add_ovf_clear got=%0b exp=1", obs_mm[0]);
    end
  endtask

  task automatic test_threshold();
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick(1, 1, 1, 0, 0, 0, 0, 0, 0);
      respond(0, 0, 0, 0, 1, 0);
      checks++;
      if (al_w[1] !== ((k == 2) ? 1'b1 : 1'b0) || dmis(1) != k + 1) begin
        failures++;
        $display("FAIL thresh3_step%0d alarm=%0b mis=%0d exp alarm=%0b mis=%0d",
                 k, al_w[1], dmis(1), (k == 2), k + 1);
      end
    end
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (al_w[1] !== 1'b0 || dchk(1) != 0 || dmis(1) != 0) begin
      failures++;
      $display("FAIL thresh3_clear alarm=%0b chk=%0d mis=%0d exp 0 0 0", al_w[1], dchk(1), dmis(1));
    end
  endtask

  task automatic test_clear_coincident();
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(1, 2, 2, 2, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 5, 0, 0, 0, 1);
    checks++;
    if (obs_mm[0] !== 1'b1 || dchk(0) != 1 || dmis(0) != 1 || fa_w[0] !== 4'd2
        || fb_w[0] !== 4'd2 || fo_w[0] !== 2'd2) begin
      failures++;
      $display("FAIL clr_with_check mm=%0b chk=%0d mis=%0d fa=%0d fb=%0d fo=%0d exp 1 1 1 2 2 2",
               obs_mm[0], dchk(0), dmis(0), fa_w[0], fb_w[0], fo_w[0]);
    end
    tick(1, 4, 4, 3, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 4, 0, 0, 0, 0);
    checks++;
    if (obs_mm[0] !== 1'b0 || dchk(0) != 1 || dmis(0) != 0) begin
      failures++;
      $display("FAIL clr_with_valid mm=%0b chk=%0d mis=%0d exp 0 1 0", obs_mm[0], dchk(0), dmis(0));
    end
  endtask

  task automatic test_reset_midcheck();
    do_reset();
    tick(1, 7, 9, 0, 0, 0, 0, 0, 0);
    dut_result = 4'h5; dut_carry = 0; dut_zero = 0; dut_overflow = 0;
    in_valid = 0;
    #2 rst_n = 1'b0;
    model_clear_all();
    #2 rst_n = 1'b1;
    #0.5;
    checks++;
    if (mm_w[0] !== 1'b0) begin
      failures++; $display("FAIL midcheck_mismatch got=%0b exp=0", mm_w[0]);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dchk(i) != 0 || dmis(i) != 0) begin
        failures++;
        $display("FAIL midcheck_counts inst%0d chk=%0d mis=%0d exp 0 0", i, dchk(i), dmis(i));
      end
    end
  endtask

  task automatic test_back_to_back_sat();
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) respond(1, k, k + 3, k % 4, 0, 0);
    respond(0, 0, 0, 0, 0, 0);
    checks++;
    if (dchk(2) != 3 || dchk(0) != 5) begin
      failures++;
      $display("FAIL sat_check_cnt w2=%0d w16=%0d exp w2=3 w16=5", dchk(2), dchk(0));
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      respond($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 3), $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_mm[i] !== exp_mm || dchk(i) != m_chk[i] || dmis(i) != m_mis[i]
            || al_w[i] !== (m_st[i] == 2) || int'(fa_w[i]) != m_fa[i]
            || int'(fb_w[i]) != m_fb[i] || int'(fo_w[i]) != m_fo[i]) begin
          failures++;
          $display("FAIL random n=%0d inst%0d got mm=%0b chk=%0d mis=%0d al=%0b f=%0d/%0d/%0d exp mm=%0b chk=%0d mis=%0d al=%0b f=%0d/%0d/%0d",
                   n, i, obs_mm[i], dchk(i), dmis(i), al_w[i], fa_w[i], fb_w[i], fo_w[i],
                   exp_mm, m_chk[i], m_mis[i], (m_st[i] == 2), m_fa[i], m_fb[i], m_fo[i]);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add_basic();
    test_sub_capture();
    test_overflow();
    test_threshold();
    test_clear_coincident();
    test_reset_midcheck();
    test_back_to_back_sat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
